// File: rtl/decode_queue_pkg.sv
// Shared types and decode tables for the buffered RV32 decode stage.
// A table row matches when (ir & IR_MASK) == IR_FRMT. Earlier rows win.
package decode_queue_pkg;

  typedef logic [4:0] RegAddr;

  typedef enum logic [2:0] {
    T_NONE, T_R, T_I, T_S, T_B, T_U, T_J, T_CSR
  } IrType;

  typedef enum logic [5:0] {
    OP_NOP,
    OP_LUI, OP_AUIPC, OP_JAL, OP_JALR,
    OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU,
    OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU,
    OP_SB, OP_SH, OP_SW,
    OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI,
    OP_SLLI, OP_SRLI, OP_SRAI,
    OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND,
    OP_FENCE, OP_ECALL, OP_EBREAK, OP_URET, OP_CSRRSI, OP_CSRRCI
  } IrOp;

  typedef struct packed {
    IrOp   op;
    IrType fmt;
    logic  useRs1;
    logic  useRs2;
    logic  useRd;
    logic  memRead;
    logic  memWrite;
    logic  ctrlFlow;
  } Signal;

  localparam Signal SIG_NOP = '0;

  typedef struct packed {
    IrOp   op;
    IrType fmt;
  } IrCtrl;

  localparam int NUM_IR = 43;

  localparam logic [31:0] M7  = 32'h0000_007f;
  localparam logic [31:0] M3  = 32'h0000_707f;
  localparam logic [31:0] M10 = 32'hfe00_707f;
  localparam logic [31:0] MF  = 32'hffff_ffff;

  localparam logic [31:0] IR_MASK [NUM_IR] = '{
    M7, M7, M7, M3,
    M3, M3, M3, M3, M3, M3,
    M3, M3, M3, M3, M3,
    M3, M3, M3,
    M3, M3, M3, M3, M3, M3,
    M10, M10, M10,
    M10, M10, M10, M10, M10, M10, M10, M10, M10, M10,
    M3, MF, MF, MF, M3, M3
  };

  localparam logic [31:0] IR_FRMT [NUM_IR] = '{
    32'h0000_0037, 32'h0000_0017, 32'h0000_006f, 32'h0000_0067,
    32'h0000_0063, 32'h0000_1063, 32'h0000_4063, 32'h0000_5063, 32'h0000_6063, 32'h0000_7063,
    32'h0000_0003, 32'h0000_1003, 32'h0000_2003, 32'h0000_4003, 32'h0000_5003,
    32'h0000_0023, 32'h0000_1023, 32'h0000_2023,
    32'h0000_0013, 32'h0000_2013, 32'h0000_3013, 32'h0000_4013, 32'h0000_6013, 32'h0000_7013,
    32'h0000_1013, 32'h0000_5013, 32'h4000_5013,
    32'h0000_0033, 32'h4000_0033, 32'h0000_1033, 32'h0000_2033, 32'h0000_3033,
    32'h0000_4033, 32'h0000_5033, 32'h4000_5033, 32'h0000_6033, 32'h0000_7033,
    32'h0000_000f, 32'h0000_0073, 32'h0010_0073, 32'h0020_0073, 32'h0000_6073, 32'h0000_7073
  };

  localparam IrCtrl IR_CTRL [NUM_IR] = '{
    '{OP_LUI, T_U}, '{OP_AUIPC, T_U}, '{OP_JAL, T_J}, '{OP_JALR, T_I},
    '{OP_BEQ, T_B}, '{OP_BNE, T_B}, '{OP_BLT, T_B}, '{OP_BGE, T_B}, '{OP_BLTU, T_B}, '{OP_BGEU, T_B},
    '{OP_LB, T_I}, '{OP_LH, T_I}, '{OP_LW, T_I}, '{OP_LBU, T_I}, '{OP_LHU, T_I},
    '{OP_SB, T_S}, '{OP_SH, T_S}, '{OP_SW, T_S},
    '{OP_ADDI, T_I}, '{OP_SLTI, T_I}, '{OP_SLTIU, T_I}, '{OP_XORI, T_I}, '{OP_ORI, T_I}, '{OP_ANDI, T_I},
    '{OP_SLLI, T_I}, '{OP_SRLI, T_I}, '{OP_SRAI, T_I},
    '{OP_ADD, T_R}, '{OP_SUB, T_R}, '{OP_SLL, T_R}, '{OP_SLT, T_R}, '{OP_SLTU, T_R},
    '{OP_XOR, T_R}, '{OP_SRL, T_R}, '{OP_SRA, T_R}, '{OP_OR, T_R}, '{OP_AND, T_R},
    '{OP_FENCE, T_NONE}, '{OP_ECALL, T_NONE}, '{OP_EBREAK, T_NONE}, '{OP_URET, T_NONE},
    '{OP_CSRRSI, T_CSR}, '{OP_CSRRCI, T_CSR}
  };

endpackage

// File: rtl/decode_queue_decode.sv
// Purely combinational RV32 decoder: instruction word to control bundle,
// register indices, sign-extended immediate and illegal flag.
module rv_decode_comb
  import decode_queue_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int ECALL_RS1 = 17,
  parameter int ECALL_RS2 = 10,
  parameter int ECALL_RD  = 11
) (
  input  logic [31:0]     ir_i,
  output Signal           sig_o,
  output RegAddr          rs1_o,
  output RegAddr          rs2_o,
  output RegAddr          rd_o,
  output logic [XLEN-1:0] imm_o,
  output logic            illegal_o
);

  logic        hit;
  IrCtrl       ctrl;
  logic        isEcall;
  Signal       sig;
  logic [31:0] imm32;

  always_comb begin
    hit  = 1'b0;
    ctrl = '{OP_NOP, T_NONE};
    for (int i = 0; i < NUM_IR; i++) begin
      if (!hit && ((ir_i & IR_MASK[i]) == IR_FRMT[i])) begin
        hit  = 1'b1;
        ctrl = IR_CTRL[i];
      end
    end
  end

  assign isEcall = hit && (ctrl.op == OP_ECALL);

  // ECALL carries its syscall registers implicitly, so all three operands are flagged.
  always_comb begin
    sig = SIG_NOP;
    if (hit) begin
      sig.op       = ctrl.op;
      sig.fmt      = ctrl.fmt;
      sig.useRs1   = (ctrl.fmt inside {T_R, T_I, T_S, T_B}) || isEcall;
      sig.useRs2   = (ctrl.fmt inside {T_R, T_S, T_B}) || isEcall;
      sig.useRd    = (ctrl.fmt inside {T_R, T_I, T_U, T_J, T_CSR}) || isEcall;
      sig.memRead  = ctrl.op inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU};
      sig.memWrite = (ctrl.fmt == T_S);
      sig.ctrlFlow = (ctrl.fmt inside {T_B, T_J}) || (ctrl.op == OP_JALR);
    end
  end

  always_comb begin
    case (sig.fmt)
      T_I:     imm32 = {{20{ir_i[31]}}, ir_i[31:20]};
      T_S:     imm32 = {{20{ir_i[31]}}, ir_i[31:25], ir_i[11:7]};
      T_B:     imm32 = {{19{ir_i[31]}}, ir_i[31], ir_i[7], ir_i[30:25], ir_i[11:8], 1'b0};
      T_U:     imm32 = {ir_i[31:12], 12'b0};
      T_J:     imm32 = {{11{ir_i[31]}}, ir_i[31], ir_i[19:12], ir_i[20], ir_i[30:21], 1'b0};
      default: imm32 = '0;
    endcase
  end

  assign sig_o     = sig;
  assign illegal_o = !hit;
  assign imm_o     = XLEN'($signed(imm32));
  assign rs1_o     = !sig.useRs1 ? '0 : (isEcall ? RegAddr'(ECALL_RS1) : ir_i[19:15]);
  assign rs2_o     = !sig.useRs2 ? '0 : (isEcall ? RegAddr'(ECALL_RS2) : ir_i[24:20]);
  assign rd_o      = !sig.useRd  ? '0 : (isEcall ? RegAddr'(ECALL_RD)  : ir_i[11:7]);

endmodule

// File: rtl/decode_queue.sv
// Buffered decode stage: DEPTH-entry (pc, ir) FIFO with the head entry decoded,
// optional registered output stage, synchronous flush for redirects.
module decode_queue
  import decode_queue_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int XLEN      = 32,
  parameter int OUT_REG   = 0,
  parameter int ECALL_RS1 = 17,
  parameter int ECALL_RS2 = 10,
  parameter int ECALL_RD  = 11
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [XLEN-1:0]            in_pc,
  input  logic [31:0]                in_ir,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [XLEN-1:0]            out_pc,
  output logic [31:0]                out_ir,
  output RegAddr                     out_rs1,
  output RegAddr                     out_rs2,
  output RegAddr                     out_rd,
  output logic [XLEN-1:0]            out_imm,
  output Signal                      out_sig,
  output logic                       out_illegal,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [XLEN-1:0] pcMemQ [DEPTH];
  logic [31:0]     irMemQ [DEPTH];
  logic [AW-1:0]   wrPtrQ, wrPtrD, rdPtrQ, rdPtrD;
  logic [CW-1:0]   countQ, countD;
  logic            push, popFifo, headValid;
  logic [XLEN-1:0] headPc, decImm;
  logic [31:0]     headIr;
  RegAddr          decRs1, decRs2, decRd;
  Signal           decSig;
  logic            decIllegal;

  logic            vRaw, illRaw;
  logic [XLEN-1:0] pcRaw, immRaw;
  logic [31:0]     irRaw;
  RegAddr          rs1Raw, rs2Raw, rdRaw;
  Signal           sigRaw;

  assign in_ready  = (countQ != CW'(DEPTH));
  assign headValid = (countQ != '0);
  assign headPc    = pcMemQ[rdPtrQ];
  assign headIr    = irMemQ[rdPtrQ];
  assign push      = in_valid && in_ready;
  assign count     = countQ;

  rv_decode_comb #(
    .XLEN(XLEN), .ECALL_RS1(ECALL_RS1), .ECALL_RS2(ECALL_RS2), .ECALL_RD(ECALL_RD)
  ) uDecode (
    .ir_i(headIr), .sig_o(decSig), .rs1_o(decRs1), .rs2_o(decRs2), .rd_o(decRd),
    .imm_o(decImm), .illegal_o(decIllegal)
  );

  // Flush wins over any push or pop at the same edge, dropping the offered word too.
  always_comb begin
    wrPtrD = wrPtrQ;
    rdPtrD = rdPtrQ;
    countD = countQ;
    if (flush) begin
      wrPtrD = '0;
      rdPtrD = '0;
      countD = '0;
    end else begin
      if (push)    wrPtrD = wrPtrQ + AW'(1);
      if (popFifo) rdPtrD = rdPtrQ + AW'(1);
      countD = countQ + CW'(push) - CW'(popFifo);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtrQ <= '0;
      rdPtrQ <= '0;
      countQ <= '0;
    end else begin
      wrPtrQ <= wrPtrD;
      rdPtrQ <= rdPtrD;
      countQ <= countD;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) begin
      pcMemQ[wrPtrQ] <= in_pc;
      irMemQ[wrPtrQ] <= in_ir;
    end
  end

  generate
    if (OUT_REG == 0) begin : gDirect
      assign popFifo = headValid && out_ready;
      assign vRaw    = headValid;
      assign pcRaw   = headPc;
      assign irRaw   = headIr;
      assign rs1Raw  = decRs1;
      assign rs2Raw  = decRs2;
      assign rdRaw   = decRd;
      assign immRaw  = decImm;
      assign sigRaw  = decSig;
      assign illRaw  = decIllegal;
    end else begin : gStaged
      logic            stValidQ, stIllegalQ, stLoad;
      logic [XLEN-1:0] stPcQ, stImmQ;
      logic [31:0]     stIrQ;
      RegAddr          stRs1Q, stRs2Q, stRdQ;
      Signal           stSigQ;

      // The stage refills whenever it is empty or being consumed, keeping full throughput.
      assign stLoad  = !stValidQ || out_ready;
      assign popFifo = stLoad && headValid;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          stValidQ   <= 1'b0;
          stPcQ      <= '0;
          stIrQ      <= '0;
          stRs1Q     <= '0;
          stRs2Q     <= '0;
          stRdQ      <= '0;
          stImmQ     <= '0;
          stSigQ     <= SIG_NOP;
          stIllegalQ <= 1'b0;
        end else if (flush) begin
          stValidQ   <= 1'b0;
          stPcQ      <= '0;
          stIrQ      <= '0;
          stRs1Q     <= '0;
          stRs2Q     <= '0;
          stRdQ      <= '0;
          stImmQ     <= '0;
          stSigQ     <= SIG_NOP;
          stIllegalQ <= 1'b0;
        end else if (stLoad) begin
          stValidQ   <= headValid;
          stPcQ      <= headPc;
          stIrQ      <= headIr;
          stRs1Q     <= decRs1;
          stRs2Q     <= decRs2;
          stRdQ      <= decRd;
          stImmQ     <= decImm;
          stSigQ     <= decSig;
          stIllegalQ <= decIllegal;
        end
      end

      assign vRaw   = stValidQ;
      assign pcRaw  = stPcQ;
      assign irRaw  = stIrQ;
      assign rs1Raw = stRs1Q;
      assign rs2Raw = stRs2Q;
      assign rdRaw  = stRdQ;
      assign immRaw = stImmQ;
      assign sigRaw = stSigQ;
      assign illRaw = stIllegalQ;
    end
  endgenerate

  // Outputs read as zero whenever nothing is presented, so stale storage never leaks out.
  assign out_valid   = vRaw;
  assign out_pc      = vRaw ? pcRaw  : '0;
  assign out_ir      = vRaw ? irRaw  : '0;
  assign out_rs1     = vRaw ? rs1Raw : '0;
  assign out_rs2     = vRaw ? rs2Raw : '0;
  assign out_rd      = vRaw ? rdRaw  : '0;
  assign out_imm     = vRaw ? immRaw : '0;
  assign out_sig     = vRaw ? sigRaw : SIG_NOP;
  assign out_illegal = vRaw && illRaw;

endmodule
